// File: rtl/pll_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pll_slot_arbiter
// Brief    : Frame-synchronous round-robin TDM arbiter sharing one fast-domain
//            resource among NREQ requesters per slow-clock period.
// Revision : 1.0
// ============================================================================
module pll_slot_arbiter #(
    parameter  int RATIO = 8,
    parameter  int NREQ  = 4,
    parameter  int DW    = 24,
    localparam int PW    = $clog2(RATIO),
    localparam int SW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PW-1:0]      phase,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               err_clr,
    output logic [NREQ-1:0]    gnt,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [SW-1:0]      out_src,
    output logic               locked,
    output logic               sync_err
);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     last_phase_q;
    logic [PW-1:0]     expected;
    logic [NREQ-1:0]   pending_q, pending_d;
    logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic [SW-1:0]     out_src_q, out_src_d;
    logic              sync_err_q, sync_err_d;
    logic [DW-1:0]     snap_q [NREQ];

    logic              disc;
    logic              snap_en;
    logic              decide;
    logic              pick_found;
    logic [SW-1:0]     pick_k;
    logic [SW:0]       cand;

    assign expected = (last_phase_q == PW'(RATIO - 1)) ? '0 : last_phase_q + PW'(1);

    assign disc    = (state_q == ST_LOCKED) && (phase != expected);
    // Phase 0 snapshots both when acquiring lock and on every continuous wrap.
    assign snap_en = (phase == '0) && !disc;
    assign decide  = (state_q == ST_LOCKED) && !disc && (phase != '0) && (pending_q != '0);

    // Cyclic first-set search over pending, starting at the round-robin pointer.
    always_comb begin
        pick_found = 1'b0;
        pick_k     = '0;
        cand       = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (SW+1)'(i);
            if (cand >= (SW+1)'(NREQ)) begin
                cand = cand - (SW+1)'(NREQ);
            end
            if (!pick_found && pending_q[cand[SW-1:0]]) begin
                pick_found = 1'b1;
                pick_k     = cand[SW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = '0;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        sync_err_d  = sync_err_q;

        if (err_clr) begin
            sync_err_d = 1'b0;
        end

        if (disc) begin
            state_d    = ST_UNLOCKED;
            pending_d  = '0;
            sync_err_d = 1'b1;
        end else if (snap_en) begin
            state_d   = ST_LOCKED;
            pending_d = req;
        end else if (decide && pick_found) begin
            pending_d   = pending_q & ~(NREQ'(1) << pick_k);
            rr_ptr_d    = (pick_k == SW'(NREQ - 1)) ? '0 : pick_k + SW'(1);
            gnt_d       = NREQ'(1) << pick_k;
            out_valid_d = 1'b1;
            out_data_d  = snap_q[pick_k];
            out_src_d   = pick_k;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_UNLOCKED;
            last_phase_q <= PW'(RATIO - 1);
            pending_q    <= '0;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_phase_q <= phase;
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            sync_err_q   <= sync_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                snap_q[k] <= '0;
            end
        end else if (snap_en) begin
            for (int k = 0; k < NREQ; k++) begin
                snap_q[k] <= req_data[k*DW +: DW];
            end
        end
    end

    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign locked    = (state_q == ST_LOCKED);
    assign sync_err  = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_slot_arbiter
// Brief    : Directed vector bench for pll_slot_arbiter (NREQ=4 and NREQ=7).
// Revision : 1.0
// ============================================================================
module tb_pll_slot_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   phase = 3'd7;
    logic [3:0]   req = '0;
    logic [95:0]  req_data = '0;
    logic         err_clr = 1'b0;
    logic [3:0]   gnt;
    logic         out_valid;
    logic [23:0]  out_data;
    logic [1:0]   out_src;
    logic         locked;
    logic         sync_err;

    logic [2:0]   phase7 = 3'd1;
    logic [6:0]   req7 = '0;
    logic [167:0] req_data7 = '0;
    logic [6:0]   gnt7;
    logic         out_valid7;
    logic [23:0]  out_data7;
    logic [2:0]   out_src7;
    logic         locked7;
    logic         sync_err7;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pll_slot_arbiter #(.RATIO(8), .NREQ(4), .DW(24)) u_dut (
        .clk(clk), .rst_n(rst_n), .phase(phase), .req(req), .req_data(req_data),
        .err_clr(err_clr), .gnt(gnt), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .locked(locked), .sync_err(sync_err)
    );

    pll_slot_arbiter #(.RATIO(8), .NREQ(7), .DW(24)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .phase(phase7), .req(req7), .req_data(req_data7),
        .err_clr(err_clr), .gnt(gnt7), .out_valid(out_valid7), .out_data(out_data7),
        .out_src(out_src7), .locked(locked7), .sync_err(sync_err7)
    );

    typedef struct {
        logic [2:0]  ph;
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic        vld;
        logic [23:0] dat;
        logic [1:0]  src;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int ph, input int rq, input int g, input int v,
                       input int d, input int s);
        vec_t r;
        r.ph  = 3'(ph);
        r.req = 4'(rq);
        r.gnt = 4'(g);
        r.vld = 1'(v);
        r.dat = 24'(d);
        r.src = 2'(s);
        vecs.push_back(r);
    endtask

    task automatic add_idle(input int p0, input int p1, input int d, input int s);
        for (int p = p0; p <= p1; p++) add(p, 0, 0, 0, d, s);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int ph, input int rq);
        phase = 3'(ph);
        req   = 4'(rq);
        tick();
    endtask

    task automatic step7(input int ph, input int rq);
        phase7 = 3'(ph);
        req7   = 7'(rq);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) req_data[k*24 +: 24] = 24'(16 + k);
        for (int k = 0; k < 7; k++) req_data7[k*24 +: 24] = 24'(32 + k);

        // Frame A: all four requesters, grants 0..3 at phases 2..5
        add(0, 'hF, 0, 0, 'h00, 0);
        add(1, 'hF, 1, 1, 'h10, 0);
        add(2, 'hF, 2, 1, 'h11, 1);
        add(3, 'hE, 4, 1, 'h12, 2);
        add(4, 'hC, 8, 1, 'h13, 3);
        add(5, 'h8, 0, 0, 'h13, 3);
        add_idle(6, 7, 'h13, 3);
        // Frame B: single requester 1
        add(0, 'h2, 0, 0, 'h13, 3);
        add(1, 'h2, 2, 1, 'h11, 1);
        add(2, 'h2, 0, 0, 'h11, 1);
        add_idle(3, 7, 'h11, 1);
        // Frame C: round robin from pointer 2 -> 3, 0, 1
        add(0, 'hB, 0, 0, 'h11, 1);
        add(1, 'hB, 8, 1, 'h13, 3);
        add(2, 'hB, 1, 1, 'h10, 0);
        add(3, 'h3, 2, 1, 'h11, 1);
        add(4, 'h2, 0, 0, 'h11, 1);
        add_idle(5, 7, 'h11, 1);
        // Frame D: late request, not served this frame
        add_idle(0, 2, 'h11, 1);
        for (int p = 3; p <= 7; p++) add(p, 'h4, 0, 0, 'h11, 1);
        // Frame E: late request served at phase 2
        add(0, 'h4, 0, 0, 'h11, 1);
        add(1, 'h4, 4, 1, 'h12, 2);
        add(2, 'h4, 0, 0, 'h12, 2);
        add_idle(3, 7, 'h12, 2);

        // Reset state
        repeat (3) tick();
        chk("rst_gnt", 0, 32'(gnt), 32'(0));
        chk("rst_valid", 0, 32'(out_valid), 32'(0));
        chk("rst_data", 0, 32'(out_data), 32'(0));
        chk("rst_src", 0, 32'(out_src), 32'(0));
        chk("rst_locked", 0, 32'(locked), 32'(0));
        chk("rst_err", 0, 32'(sync_err), 32'(0));
        chk("rst_locked7", 0, 32'(locked7), 32'(0));
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(int'(vecs[i].ph), int'(vecs[i].req));
            chk("tbl_gnt", i, 32'(gnt), 32'(vecs[i].gnt));
            chk("tbl_valid", i, 32'(out_valid), 32'(vecs[i].vld));
            chk("tbl_data", i, 32'(out_data), 32'(vecs[i].dat));
            chk("tbl_src", i, 32'(out_src), 32'(vecs[i].src));
            chk("tbl_locked", i, 32'(locked), 32'(1));
            chk("tbl_err", i, 32'(sync_err), 32'(0));
        end

        // Async reset mid-service (pointer is 3 here)
        step(0, 'hF);
        step(1, 'hF); chk("ar_gnt", 1, 32'(gnt), 32'(8));
        step(2, 'hF); chk("ar_gnt", 2, 32'(gnt), 32'(1));
        step(3, 'hF); chk("ar_gnt", 3, 32'(gnt), 32'(2));
        chk("ar_data", 3, 32'(out_data), 32'('h11));
        phase = 3'd4;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_async_gnt", 4, 32'(gnt), 32'(0));
        chk("ar_async_valid", 4, 32'(out_valid), 32'(0));
        chk("ar_async_locked", 4, 32'(locked), 32'(0));
        chk("ar_async_data", 4, 32'(out_data), 32'(0));
        chk("ar_async_src", 4, 32'(out_src), 32'(0));
        tick();
        rst_n = 1'b1;
        for (int p = 5; p <= 7; p++) begin
            step(p, 'hF);
            chk("ar_unl_gnt", p, 32'(gnt), 32'(0));
            chk("ar_unl_locked", p, 32'(locked), 32'(0));
        end
        step(0, 'hF); chk("ar_relock", 0, 32'(locked), 32'(1));
        step(1, 'hF); chk("ar_first_gnt", 1, 32'(gnt), 32'(1));
        chk("ar_first_data", 1, 32'(out_data), 32'('h10));

        // Discontinuity 3 -> 6 while pending = 1100
        step(2, 'hE); chk("dc_gnt", 2, 32'(gnt), 32'(2));
        step(3, 'hC); chk("dc_gnt", 3, 32'(gnt), 32'(4));
        chk("dc_data", 3, 32'(out_data), 32'('h12));
        step(6, 'h8);
        chk("dc_locked", 6, 32'(locked), 32'(0));
        chk("dc_err", 6, 32'(sync_err), 32'(1));
        chk("dc_gnt", 6, 32'(gnt), 32'(0));
        chk("dc_valid", 6, 32'(out_valid), 32'(0));
        step(7, 'h8);
        chk("dc_gnt", 7, 32'(gnt), 32'(0));
        chk("dc_locked", 7, 32'(locked), 32'(0));
        step(0, 'h8);
        chk("dc_relock", 0, 32'(locked), 32'(1));
        chk("dc_gnt", 0, 32'(gnt), 32'(0));
        step(1, 'h8);
        chk("dc_resume_gnt", 1, 32'(gnt), 32'(8));
        chk("dc_resume_src", 1, 32'(out_src), 32'(3));
        chk("dc_err_sticky", 1, 32'(sync_err), 32'(1));
        err_clr = 1'b1;
        step(2, 'h0);
        err_clr = 1'b0;
        chk("dc_err_clr", 2, 32'(sync_err), 32'(0));
        chk("dc_gnt", 2, 32'(gnt), 32'(0));

        // NREQ=7: grants 0..6 at phases 2..7 and the following phase 0
        step7(0, 'h7F);
        chk("e7_locked", 0, 32'(locked7), 32'(1));
        chk("e7_gnt", 0, 32'(gnt7), 32'(0));
        for (int p = 1; p <= 7; p++) begin
            step7(p, 'h7F);
            chk("e7_gnt", p, 32'(gnt7), 32'(1) << (p - 1));
            chk("e7_data", p, 32'(out_data7), 32'(32 + p - 1));
            chk("e7_src", p, 32'(out_src7), 32'(p - 1));
        end
        step7(0, 'h44);
        chk("e7_snap_gnt", 0, 32'(gnt7), 32'(0));
        chk("e7_snap_locked", 0, 32'(locked7), 32'(1));
        step7(1, 'h44);
        chk("e7_f2_gnt", 1, 32'(gnt7), 32'('h04));
        chk("e7_f2_data", 1, 32'(out_data7), 32'('h22));
        step7(2, 'h44);
        chk("e7_f2_gnt", 2, 32'(gnt7), 32'('h40));
        chk("e7_f2_src", 2, 32'(out_src7), 32'(6));
        step7(3, 'h00);
        chk("e7_f2_gnt", 3, 32'(gnt7), 32'(0));
        chk("e7_f2_valid", 3, 32'(out_valid7), 32'(0));
        chk("e7_err", 3, 32'(sync_err7), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_slot_arbiter.md
# pll_slot_arbiter

Time-division arbiter that shares one fast-clock-domain resource (e.g. a multiplier or FIFO write port) among up to RATIO-1 requesters within each slow-clock period. It consumes the phase count produced by the slow/fast PLL phase counter and treats each wrap of that count to 0 as a frame boundary. At each boundary it snapshots pending requests and data, then serves them one per fast cycle in round-robin order. It detects phase discontinuities, drops out of lock, and raises a sticky error.

## Interface
- RATIO, 8, slow-to-fast clock period ratio; must match the phase counter.
- NREQ, 4, number of requesters; legal range is 1..RATIO-1.
- DW, 24, data width per requester.
- PW (localparam), $clog2(RATIO), phase width.
- SW (localparam), max($clog2(NREQ),1), source index width.

Ports:
- clk  in  1  fast clock.
- rst_n  in  1  asynchronous, active-low reset.
- phase  in  PW  phase count from the phase counter; 0 on the fast cycle after a slow edge.
- req  in  NREQ  per-requester level request; held until the matching gnt.
- req_data  in  NREQ*DW  requester k's data is at [k*DW +: DW].
- err_clr  in  1  clears sync_err.
- gnt  out  NREQ  one-hot, one-cycle grant.
- out_valid  out  1  out_data/out_src are valid this cycle.
- out_data  out  DW  granted requester's snapshot data.
- out_src  out  SW  granted requester index.
- locked  out  1  arbiter is in the LOCKED state.
- sync_err  out  1  sticky phase-discontinuity flag.

## Operation
- Reset values: gnt=0, out_valid=0, out_data=0, out_src=0, locked=0, sync_err=0. Internal: pending=0, rr_ptr=0, last_phase=RATIO-1.
- last_phase is registered every cycle. expected = (last_phase==RATIO-1) ? 0 : last_phase+1.
- The state machine has two states, UNLOCKED and LOCKED.
  - UNLOCKED: no grants are issued. On phase==0 the arbiter goes to LOCKED and takes a snapshot the same cycle.
  - LOCKED, phase!=expected: the arbiter goes to UNLOCKED, clears pending, and sets sync_err. No decision is made this cycle.
  - LOCKED, phase==0 and continuous: take a snapshot.
  - LOCKED, phase in 1..RATIO-1 and pending!=0: make a decision.
- Snapshot: pending <= req, and each requester's req_data is captured into a per-requester register. If the snapshot cycle coincides with a decision cycle, the snapshot wins; this cannot occur when NREQ<=RATIO-1.
- Decision:
  - k = first set bit of pending, searching cyclically from rr_ptr.
  - Clear pending[k].
  - rr_ptr <= (k==NREQ-1) ? 0 : k+1.
  - Register outputs: gnt <= 1<<k, out_valid <= 1, out_data <= snap[k], out_src <= k.
- Cycles with no decision register gnt=0 and out_valid=0. out_data and out_src hold their previous values.
- Requests that rise after the phase-0 cycle wait for the next frame.
  - A requester must keep req high until it sees gnt.
  - It may drop req, or change data, on the cycle after gnt.
  - If req is still high at the next phase 0 after being served, it is re-snapshotted and served again.
- sync_err:
  - Set on a discontinuity.
  - Cleared by err_clr when no discontinuity occurs in the same cycle; a set in the same cycle wins.
  - Unaffected by the lock state.
- locked mirrors state==LOCKED.

## Timing
- Phase 0 at cycle t: snapshot. The first decision happens at t+1 (phase 1), and the first gnt/out_valid appears at t+2.
- At most one grant per cycle. All NREQ requests are served by phase NREQ. The last gnt is visible at phase NREQ+1 (mod RATIO), so it reaches the next phase 0 only when NREQ=RATIO-1.
- Latency from the snapshot to the n-th grant (n = 1..popcount) is n+1 cycles.
- Discontinuity at cycle t: locked falls at t+1 and sync_err rises at t+1. A grant decided at t-1 still appears at t. No gnt appears from t+1 until re-lock.
- Re-lock: the first phase==0 after a discontinuity sets locked one cycle later. Grants follow the normal phase-0 timing.
- Reset asserted mid-frame: all outputs drop asynchronously to their reset values, and pending and rr_ptr are cleared.

## Test plan
- Reset, then phase counting 0..7 repeatedly (RATIO=8) with req=4'b1111 held until grant, data k=0x10+k:
  - locked rises one cycle after the first phase 0.
  - Grants 0,1,2,3 appear at phases 2,3,4,5.
  - out_data=0x10..0x13 and out_src=0..3.
- Round robin: frame 1 with req=4'b0010 grants 1. Frame 2 with req=4'b1011 grants 3, then 0, then 1.
- Late request: req[2] rises at phase 3. There is no grant this frame; gnt[2] appears at phase 2 of the next frame.
- Discontinuity: phase jumps 3→6 while pending=4'b1100.
  - locked falls and sync_err rises one cycle later; no further gnt.
  - At the next phase 0, locked rises and service resumes.
  - sync_err stays 1 until err_clr, then reads 0.
- Async reset asserted at phase 4 mid-service: gnt=0, out_valid=0, locked=0 immediately. After release, the first grant is at phase 2 of the first complete frame.
- Edge config NREQ=7, RATIO=8, all req: grants 0..6 at phases 2..7 and the next phase 0, each cycle one-hot. The frame-boundary snapshot still occurs.
